pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the next generation of the per-stage IF/ID/EXE/MEM latches. It carries a generic control vector and a generic data vector between stages, using a valid/ready handshake in place of a free-running capture. It keeps the legacy freeze and flush controls and adds an optional 2-entry skid buffer so that in_ready is registered. It sits between any two pipeline stages and is instantiated once per stage boundary.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, default
// payload widths and the control-field layout used to pack in_ctrl/out_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stage_state_e;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 8;

  // Control vector bit layout shared by every stage boundary
  localparam int CTRL_WB_EN      = 0;
  localparam int CTRL_MEM_R      = 1;
  localparam int CTRL_MEM_W      = 2;
  localparam int CTRL_EXE_CMD_LO = 3;
  localparam int CTRL_EXE_CMD_W  = 4;

  function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
    input logic                      wb_en,
    input logic                      mem_r,
    input logic                      mem_w,
    input logic [CTRL_EXE_CMD_W-1:0] exe_cmd
  );
    logic [CTRL_W_DEF-1:0] c;
    c = '0;
    c[CTRL_WB_EN] = wb_en;
    c[CTRL_MEM_R] = mem_r;
    c[CTRL_MEM_W] = mem_w;
    c[CTRL_EXE_CMD_LO +: CTRL_EXE_CMD_W] = exe_cmd;
    return c;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// CNT_W-bit event counter with enable that sticks at its maximum value.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (en) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with freeze, flush, optional 2-entry
// skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_vld_p1;
  logic [CTRL_W-1:0] main_ctrl_p1;
  logic [DATA_W-1:0] main_data_p1;
  logic              acc;
  logic              emit;

  assign acc  = in_valid & in_ready & ~freeze;
  assign emit = main_vld_p1 & out_ready & ~freeze;

  if (SKID != 0) begin : gen_skid
    logic              skid_vld_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;
    stage_state_e      state;

    always_comb begin
      state = EMPTY;
      if (skid_vld_p1)      state = TWO;
      else if (main_vld_p1) state = ONE;
    end

    // in_ready depends only on the skid flag, breaking the out_ready path
    assign in_ready = ~freeze & ~skid_vld_p1;

    // Stage boundary: main (head) and skid (second) entries
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_vld_p1  <= 1'b0;
        main_ctrl_p1 <= '0;
        main_data_p1 <= '0;
        skid_vld_p1  <= 1'b0;
        skid_ctrl_p1 <= '0;
        skid_data_p1 <= '0;
      end else if (!freeze) begin
        unique case (state)
          EMPTY: begin
            if (acc) begin
              main_vld_p1  <= 1'b1;
              main_ctrl_p1 <= in_ctrl;
              main_data_p1 <= in_data;
            end
          end
          ONE: begin
            if (acc && emit) begin
              main_ctrl_p1 <= in_ctrl;
              main_data_p1 <= in_data;
            end else if (acc) begin
              skid_vld_p1  <= 1'b1;
              skid_ctrl_p1 <= in_ctrl;
              skid_data_p1 <= in_data;
            end else if (emit) begin
              main_vld_p1 <= 1'b0;
            end
          end
          TWO: begin
            if (emit) begin
              main_ctrl_p1 <= skid_ctrl_p1;
              main_data_p1 <= skid_data_p1;
              skid_vld_p1  <= 1'b0;
            end
          end
          default: begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
          end
        endcase
      end
    end
  end else begin : gen_single
    assign in_ready = ~freeze & (~main_vld_p1 | out_ready);

    // Stage boundary: single main register
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_vld_p1  <= 1'b0;
        main_ctrl_p1 <= '0;
        main_data_p1 <= '0;
      end else if (acc) begin
        main_vld_p1  <= 1'b1;
        main_ctrl_p1 <= in_ctrl;
        main_data_p1 <= in_data;
      end else if (emit) begin
        main_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = main_vld_p1;
  // An empty stage presents a bubble: no control bits asserted
  assign out_ctrl  = main_vld_p1 ? main_ctrl_p1 : '0;
  assign out_data  = main_data_p1;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .en (main_vld_p1 & ~out_ready & ~freeze),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (SKID=1) and a single-
// register instance (SKID=0, CNT_W=2) driven from hand-computed vectors.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Skid instance signals
  logic        s_flush, s_freeze, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_in_ctrl, s_out_ctrl;
  logic [63:0] s_in_data, s_out_data;
  logic [15:0] s_stall;

  // Single-register instance signals
  logic        d_flush, d_freeze, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [7:0]  d_in_ctrl, d_out_ctrl;
  logic [63:0] d_in_data, d_out_data;
  logic [1:0]  d_stall;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(s_flush), .freeze(s_freeze),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .stall_cnt(s_stall)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(2)) u_dut_single (
    .clk(clk), .rst(rst), .flush(d_flush), .freeze(d_freeze),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_ctrl(d_in_ctrl), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_ctrl(d_out_ctrl),
    .out_data(d_out_data), .stall_cnt(d_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs before checking
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_flush = 0; s_freeze = 0; s_in_valid = 1; s_out_ready = 0;
    s_in_ctrl = 8'hFF; s_in_data = 64'hAA;
    d_flush = 0; d_freeze = 0; d_in_valid = 1; d_out_ready = 0;
    d_in_ctrl = 8'hFF; d_in_data = 64'hBB;
    tick(); tick();
    rst = 0; s_in_valid = 0; d_in_valid = 0;
    settle();

    // Reset and idle
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_ctrl",  s_out_ctrl, 0);
    chk("rst_out_data",  s_out_data, 0);
    chk("rst_stall",     s_stall, 0);
    chk("rst_in_ready",  s_in_ready, 1);
    chk("rst_d_in_ready", d_in_ready, 1);
    chk("rst_d_out_data", d_out_data, 0);

    // Streaming 1..8 with out_ready held high
    s_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      s_in_valid = 1; s_in_data = 64'(i); s_in_ctrl = 8'(i);
      settle();
      chk($sformatf("stream_in_ready_%0d", i), s_in_ready, 1);
      tick();
      chk($sformatf("stream_valid_%0d", i), s_out_valid, 1);
      chk($sformatf("stream_data_%0d", i), s_out_data, 64'(i));
      chk($sformatf("stream_ctrl_%0d", i), s_out_ctrl, 64'(i));
    end
    s_in_valid = 0;
    tick();
    chk("stream_drain_valid", s_out_valid, 0);
    chk("stream_drain_ctrl",  s_out_ctrl, 0);

    // Backpressure: A, B accepted, C held upstream
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'hA1; s_in_ctrl = 8'h11;
    tick();
    settle();
    chk("bp_ready_after_a", s_in_ready, 1);
    s_in_data = 64'hB2; s_in_ctrl = 8'h22;
    tick();
    settle();
    chk("bp_ready_after_b", s_in_ready, 0);
    s_in_data = 64'hC3; s_in_ctrl = 8'h33;
    tick(); tick();
    chk("bp_head_a", s_out_data, 64'hA1);
    chk("bp_stall3", s_stall, 3);
    s_out_ready = 1;
    tick();
    chk("bp_out_b", s_out_data, 64'hB2);
    chk("bp_ctrl_b", s_out_ctrl, 8'h22);
    tick();
    chk("bp_out_c", s_out_data, 64'hC3);
    chk("bp_valid_c", s_out_valid, 1);
    s_in_valid = 0;
    tick();
    chk("bp_empty", s_out_valid, 0);
    chk("bp_stall_hold", s_stall, 3);

    // Flush while full with a simultaneous accept attempt
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'hD4; s_in_ctrl = 8'h44;
    tick();
    s_in_data = 64'hE5; s_in_ctrl = 8'h55;
    tick();
    s_in_data = 64'hF6; s_in_ctrl = 8'h66; s_flush = 1;
    tick();
    s_flush = 0; s_in_valid = 0;
    chk("flush_valid", s_out_valid, 0);
    chk("flush_ctrl",  s_out_ctrl, 0);
    chk("flush_data",  s_out_data, 0);
    chk("flush_stall", s_stall, 5);
    s_out_ready = 1;
    tick();
    chk("flush_no_ghost1", s_out_valid, 0);
    tick();
    chk("flush_no_ghost2", s_out_valid, 0);

    // Freeze holds a single 0x55 entry despite out_ready and in_valid
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'h55; s_in_ctrl = 8'h05;
    tick();
    s_freeze = 1; s_out_ready = 1; s_in_data = 64'h66;
    settle();
    chk("frz_in_ready", s_in_ready, 0);
    tick(); tick(); tick();
    chk("frz_data",  s_out_data, 64'h55);
    chk("frz_valid", s_out_valid, 1);
    chk("frz_stall", s_stall, 5);
    s_freeze = 0; s_in_valid = 0;
    tick();
    chk("frz_emit_once", s_out_valid, 0);

    // SKID=0: combinational in_ready and stall saturation at CNT_W=2
    d_in_valid = 1; d_in_data = 64'h77; d_in_ctrl = 8'h07;
    settle();
    chk("d_ready_empty", d_in_ready, 1);
    tick();
    settle();
    chk("d_ready_full_blocked", d_in_ready, 0);
    d_out_ready = 1;
    settle();
    chk("d_ready_comb_path", d_in_ready, 1);
    d_out_ready = 0; d_in_valid = 0;
    tick(); tick();
    chk("d_stall2", d_stall, 2);
    tick(); tick(); tick(); tick();
    chk("d_stall_sat", d_stall, 3);
    chk("d_data_held", d_out_data, 64'h77);
    chk("d_ctrl_held", d_out_ctrl, 8'h07);
    d_out_ready = 1;
    tick();
    chk("d_emitted", d_out_valid, 0);
    chk("d_ctrl_bubble", d_out_ctrl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
